// File: rtl/systolic_skew_line.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_line
//  Purpose  : Multi-lane delay line that applies the diagonal skew needed to
//             feed operand rows/columns into the systolic multiply array.
//             Lane i delays {valid, data} by BASE_DEPTH + i cycles. All lanes
//             share one stall and one synchronous flush. A registered counter
//             tracks how many valid tokens are held in the stages.
//
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             in_valid   - per-lane input valid          [LANES]
//             in_data    - lane i at [i*WIDTH +: WIDTH]  [LANES*WIDTH]
//             stall      - hold every stage, drop inputs
//             flush      - clear every stage on next edge (beats stall)
//             out_data   - last stage data per lane      [LANES*WIDTH]
//             out_valid  - last stage valid per lane     [LANES]
//             in_flight  - number of stages holding valid=1
//             busy       - in_flight != 0
//
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_line #(
    parameter  int WIDTH      = 32,
    parameter  int LANES      = 4,
    parameter  int BASE_DEPTH = 1,
    localparam int MAX_TOKENS = LANES*BASE_DEPTH + (LANES*(LANES-1))/2,
    localparam int CNT_W      = $clog2(MAX_TOKENS+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    output logic [CNT_W-1:0]       in_flight,
    output logic                   busy
);

    // ------------------------------------------------------------------------
    // Popcount in CNT_W+1 bits so the in_flight update never wraps.
    // ------------------------------------------------------------------------
    function automatic logic [CNT_W:0] f_popcount(input logic [LANES-1:0] v);
        logic [CNT_W:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) begin
            s = s + (CNT_W+1)'(v[k]);
        end
        return s;
    endfunction

    // Flat view of every stage valid bit; lane i occupies the slice starting
    // at i*BASE_DEPTH + i*(i-1)/2 with BASE_DEPTH+i bits.
    logic [MAX_TOKENS-1:0] w_all_vld;

    // ------------------------------------------------------------------------
    // Per-lane shift registers
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int c_depth  = BASE_DEPTH + i;
        localparam int c_offset = i*BASE_DEPTH + (i*(i-1))/2;

        logic [c_depth-1:0] r_vld;
        logic [WIDTH-1:0]   r_dat [c_depth];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= '0;
                for (int k = 0; k < c_depth; k++) begin
                    r_dat[k] <= '0;
                end
            end else if (flush) begin
                r_vld <= '0;
                for (int k = 0; k < c_depth; k++) begin
                    r_dat[k] <= '0;
                end
            end else if (!stall) begin
                // Data is captured regardless of valid; downstream qualifies
                // it with out_valid. The last stage is simply overwritten.
                r_vld[0] <= in_valid[i];
                r_dat[0] <= in_data[i*WIDTH +: WIDTH];
                for (int k = 1; k < c_depth; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end

        assign out_valid[i]                = r_vld[c_depth-1];
        assign out_data[i*WIDTH +: WIDTH]  = r_dat[c_depth-1];
        assign w_all_vld[c_offset +: c_depth] = r_vld;
    end : g_lane

    // ------------------------------------------------------------------------
    // Token counter. Tokens enter through stage 0 and leave when the last
    // stage (already visible on out_valid) is overwritten, so the same edge
    // that shifts the lanes updates the count.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_in_flight;
    logic [CNT_W:0]   w_cnt_next;

    assign w_cnt_next = {1'b0, r_in_flight} + f_popcount(in_valid) - f_popcount(out_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_flight <= '0;
        end else if (flush) begin
            r_in_flight <= '0;
        end else if (!stall) begin
            r_in_flight <= w_cnt_next[CNT_W-1:0];
        end
    end

    assign in_flight = r_in_flight;
    assign busy      = (r_in_flight != '0);

`ifndef SYNTHESIS
    // The counter must mirror the stage valid bits exactly.
    a_count_matches : assert property (@(posedge clk) disable iff (rst)
        r_in_flight == CNT_W'($countones(w_all_vld)));
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        int'(r_in_flight) <= MAX_TOKENS);
`endif

endmodule : systolic_skew_line
`default_nettype wire

// File: tb/tb_systolic_skew_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_skew_line
//  Purpose  : Self-checking bench for systolic_skew_line. Three instances
//             (4x1, 1x3, 8x2 lanes x base depth) share control and run the
//             same scenarios; a token scoreboard predicts when and what each
//             lane emits, keyed on the count of non-stalled edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_line;

    localparam int c_lanes [3] = '{4, 1, 8};
    localparam int c_base  [3] = '{1, 3, 2};

    logic clk = 1'b0;
    logic rst, stall, flush;
    always #5 clk = ~clk;

    logic [3:0]   in_valid0, out_valid0;
    logic [127:0] in_data0,  out_data0;
    logic [3:0]   in_flight0;
    logic         busy0;
    logic [0:0]   in_valid1, out_valid1;
    logic [31:0]  in_data1,  out_data1;
    logic [1:0]   in_flight1;
    logic         busy1;
    logic [7:0]   in_valid2, out_valid2;
    logic [255:0] in_data2,  out_data2;
    logic [5:0]   in_flight2;
    logic         busy2;

    logic [7:0]  vin [3];
    logic [31:0] din [3][8];

    always_comb begin
        in_valid0 = vin[0][3:0];
        in_valid1 = vin[1][0:0];
        in_valid2 = vin[2];
        in_data0  = '0;
        in_data2  = '0;
        for (int l = 0; l < 4; l++) in_data0[l*32 +: 32] = din[0][l];
        in_data1  = din[1][0];
        for (int l = 0; l < 8; l++) in_data2[l*32 +: 32] = din[2][l];
    end

    systolic_skew_line #(.WIDTH(32), .LANES(4), .BASE_DEPTH(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
        .stall(stall), .flush(flush), .out_data(out_data0), .out_valid(out_valid0),
        .in_flight(in_flight0), .busy(busy0));

    systolic_skew_line #(.WIDTH(32), .LANES(1), .BASE_DEPTH(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .stall(stall), .flush(flush), .out_data(out_data1), .out_valid(out_valid1),
        .in_flight(in_flight1), .busy(busy1));

    systolic_skew_line #(.WIDTH(32), .LANES(8), .BASE_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .stall(stall), .flush(flush), .out_data(out_data2), .out_valid(out_valid2),
        .in_flight(in_flight2), .busy(busy2));

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        int          inst;
        int          lane;
        int          due;
        logic [31:0] data;
    } tok_t;

    tok_t        sb [$];
    logic [7:0]  exp_ov [3];
    logic [31:0] exp_od [3][8];
    bit          exp_dk [3][8];   // expected data is known for this lane
    int          act;             // count of non-stalled, non-flushed edges
    int          n_err;
    int          n_chk;
    int          seq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_ov(input int k);
        case (k)
            0:       return {4'b0, out_valid0};
            1:       return {7'b0, out_valid1};
            default: return out_valid2;
        endcase
    endfunction

    function automatic logic [31:0] get_od(input int k, input int l);
        case (k)
            0:       return out_data0[l*32 +: 32];
            1:       return out_data1;
            default: return out_data2[l*32 +: 32];
        endcase
    endfunction

    function automatic int get_ifl(input int k);
        case (k)
            0:       return int'(in_flight0);
            1:       return int'(in_flight1);
            default: return int'(in_flight2);
        endcase
    endfunction

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input int k);
        return 8'((1 << c_lanes[k]) - 1);
    endfunction

    task automatic model_clear();
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            exp_ov[k] = '0;
            for (int l = 0; l < 8; l++) begin
                exp_od[k][l] = '0;
                exp_dk[k][l] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            int cnt;
            logic [7:0] ov;
            cnt = 0;
            foreach (sb[j]) if (sb[j].inst == k) cnt++;
            cnt += $countones(exp_ov[k]);
            ov = get_ov(k);
            for (int l = 0; l < c_lanes[k]; l++) begin
                chk($sformatf("u%0d.out_valid[%0d]", k, l), 64'(ov[l]), 64'(exp_ov[k][l]));
                if (exp_dk[k][l])
                    chk($sformatf("u%0d.out_data[%0d]", k, l), 64'(get_od(k, l)), 64'(exp_od[k][l]));
            end
            chk($sformatf("u%0d.in_flight", k), 64'(get_ifl(k)), 64'(cnt));
            chk($sformatf("u%0d.busy", k), 64'(get_busy(k)), 64'(cnt != 0));
        end
    endtask

    // One clock edge: update the model from the inputs presented across the
    // edge, then sample the DUT 1 time unit later.
    task automatic tick();
        bit was_active;
        @(posedge clk);
        was_active = !rst && !flush && !stall;
        if (rst || flush) begin
            model_clear();
        end else if (was_active) begin
            act++;
            for (int k = 0; k < 3; k++)
                for (int l = 0; l < c_lanes[k]; l++)
                    if (vin[k][l])
                        sb.push_back('{k, l, act + c_base[k] + l - 1, din[k][l]});
        end
        #1;
        if (was_active) begin
            for (int k = 0; k < 3; k++) begin
                for (int l = 0; l < c_lanes[k]; l++) begin
                    int idx;
                    idx = -1;
                    foreach (sb[j])
                        if (sb[j].inst == k && sb[j].lane == l && sb[j].due == act) idx = j;
                    if (idx >= 0) begin
                        exp_ov[k][l] = 1'b1;
                        exp_od[k][l] = sb[idx].data;
                        exp_dk[k][l] = 1'b1;
                        sb.delete(idx);
                    end else begin
                        exp_ov[k][l] = 1'b0;
                        exp_dk[k][l] = 1'b0;
                    end
                end
            end
        end
        compare_all();
    endtask

    task automatic drive(input bit all_lanes, input logic [7:0] m0);
        for (int k = 0; k < 3; k++) begin
            vin[k] = all_lanes ? lane_mask(k) : (k == 0 ? m0 : 8'h00);
            for (int l = 0; l < 8; l++) begin
                seq++;
                din[k][l] = {k[3:0], l[3:0], seq[23:0]};
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < 3; k++) vin[k] = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_skew_ov [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    localparam int         c_skew_if [5] = '{4, 3, 2, 1, 0};

    initial begin
        n_err = 0; n_chk = 0; act = 0; seq = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vin[k] = '0;
            for (int l = 0; l < 8; l++) din[k][l] = '0;
        end
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // Skew: one all-lane beat, data A0+lane.
        for (int k = 0; k < 3; k++) begin
            vin[k] = lane_mask(k);
            for (int l = 0; l < 8; l++) din[k][l] = 32'hA0 + 32'(l);
        end
        tick();
        idle(0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            chk($sformatf("skew_ov[%0d]", c), 64'(out_valid0), 64'(c_skew_ov[c]));
            chk($sformatf("skew_if[%0d]", c), 64'(in_flight0), 64'(c_skew_if[c]));
        end
        idle(10);

        // Full streaming: saturation at MAX_TOKENS for each geometry.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'h00);
            tick();
        end
        chk("sat_u0", 64'(in_flight0), 64'd10);
        chk("sat_u1", 64'(in_flight1), 64'd3);
        chk("sat_u2", 64'(in_flight2), 64'd44);
        idle(12);

        // Stall: two beats in flight, then three stalled edges.
        drive(1'b1, 8'h00); tick();
        drive(1'b1, 8'h00); tick();
        for (int k = 0; k < 3; k++) vin[k] = '0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b0;
        idle(12);

        // Flush together with stall and valid input.
        drive(1'b1, 8'h00); tick();
        drive(1'b1, 8'h00); tick();
        chk("pre_flush_if", 64'(in_flight0), 64'd7);
        drive(1'b1, 8'h00);
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("flush_ov", 64'(out_valid0), 64'd0);
        chk("flush_if", 64'(in_flight0), 64'd0);
        idle(12);

        // Asynchronous reset mid-stream with 6 tokens in u_dut0.
        drive(1'b0, 8'h0F); tick();
        drive(1'b0, 8'h07); tick();
        chk("pre_rst_if", 64'(in_flight0), 64'd6);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        compare_all();
        chk("rst_busy", 64'(busy0), 64'd0);
        drive(1'b1, 8'h00);
        tick();
        @(negedge clk);
        rst = 1'b0;
        idle(6);

        // Random traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 39) == 0);
            drive(1'b0, 8'h00);
            for (int k = 0; k < 3; k++)
                vin[k] = stall ? 8'h00 : (8'($urandom()) & lane_mask(k));
            tick();
        end
        stall = 1'b0; flush = 1'b0;
        idle(12);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_systolic_skew_line
`default_nettype wire

// File: doc/systolic_skew_line.md
# systolic_skew_line

Parametrised multi-lane delay line that feeds operand rows/columns into the systolic multiply array with the diagonal skew the array needs. Lane `i` delays its data and valid by `BASE_DEPTH + i` cycles. All lanes share a global stall and a synchronous flush, and the block reports how many valid tokens are in flight. It replaces the per-row fixed-depth delay registers with one configurable block.

## Interface
- `WIDTH`, 32, data width per lane
- `LANES`, 4, number of lanes (>= 1)
- `BASE_DEPTH`, 1, delay of lane 0 in cycles (>= 1)
- `MAX_TOKENS`, derived = `LANES*BASE_DEPTH + LANES*(LANES-1)/2`, total stage count; `CNT_W` = `$clog2(MAX_TOKENS+1)`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  LANES  per-lane input valid
- `in_data`  in  LANES*WIDTH  lane `i` at bits `[i*WIDTH +: WIDTH]`
- `stall`  in  1  high: every stage holds its value
- `flush`  in  1  synchronous clear of all stages
- `out_data`  out  LANES*WIDTH  registered, same lane packing
- `out_valid`  out  LANES  registered per-lane valid
- `in_flight`  out  CNT_W  number of stages holding valid=1
- `busy`  out  1  `in_flight != 0`

## Operation
- Lane `i` is a shift register of `D_i = BASE_DEPTH + i` stages. Each stage is {valid, data}. The last stage drives `out_valid[i]` / `out_data[i]`.
- Normal cycle (`!stall && !flush`):
  - stage 0 captures `in_valid[i]` and `in_data[i]`. Data is captured whether or not valid is set.
  - every other stage takes the previous stage.
  - the last stage value is overwritten, meaning the token is consumed downstream. There is no backpressure other than `stall`.
- Stall (`stall && !flush`): all stages hold. Inputs presented that cycle are dropped, and the upstream must not present valid data.
- Flush: all valid and data bits are cleared to 0 on the next edge, and `in_flight` becomes 0. Flush has priority over stall. Inputs presented that cycle are dropped.
- `in_flight` counter, registered:
  - normal cycle: `next = in_flight + popcount(in_valid) - popcount(out_valid)`.
  - stall: holds. Flush: 0.
  - It must always equal the popcount of all stage valid bits and never exceed `MAX_TOKENS`. Arithmetic is in `CNT_W+1` bits, with no wrap.
- `busy` is combinational from the registered `in_flight`.
- Reset (`rst` high, any time, including mid-stream): all stage valid/data = 0, `out_valid` = 0, `out_data` = 0, `in_flight` = 0, `busy` = 0. This takes effect immediately, without waiting for `clk`. The first capture happens on the first rising edge after `rst` deasserts.

## Timing
- Latency for lane `i` with no stall: valid at input before edge `t` appears at output after edge `t + D_i - 1`, i.e. `D_i` edges including the capture edge. Example: `BASE_DEPTH=1`, lane 0 gives a 1-cycle register and lane 3 gives a 4-cycle delay.
- Each stalled edge between capture and emergence adds exactly 1 cycle of latency. Order within a lane is preserved.
- Back-to-back valid tokens are accepted every non-stalled cycle per lane, giving a throughput of 1 token/lane/cycle.
- Skew invariant: tokens presented to all lanes in the same cycle emerge on consecutive cycles, lane 0 first, lane `i` exactly `i` cycles after lane 0 (stalls shift all lanes equally).
- Outputs are valid from registers only. There is no combinational path from any input to any output.

## Test plan
Defaults for all scenarios: `WIDTH=32`, `LANES=4`, `BASE_DEPTH=1`, giving `MAX_TOKENS=10`.
- Reset: assert `rst` mid-stream with 6 tokens in flight, between clock edges. Expect `out_valid=0`, `out_data=0`, `in_flight=0`, `busy=0` immediately. After release, the first token reappears only after fresh input.
- Skew: one cycle of `in_valid=4'b1111`, data lane `i = 32'hA0+i`. Expect `out_valid` = `0001`, `0010`, `0100`, `1000` on cycles 1–4 after capture, with data `A0`–`A3`. `in_flight` goes 4, 3, 2, 1, 0.
- Full streaming: `in_valid=1111` every cycle with incrementing data. `in_flight` saturates at 10 and holds. Each lane's outputs are in order, with no gaps.
- Stall: tokens in flight, `stall` held 3 cycles. Outputs and `in_flight` are frozen, and every token emerges exactly 3 cycles later than the no-stall schedule.
- Flush: with 7 tokens in flight, assert `flush` together with `stall` and `in_valid=1111`. Next cycle: all `out_valid=0`, `in_flight=0`, and no token from that cycle ever appears.
- Parameter sweep: `LANES=1`, `BASE_DEPTH=3` gives a 3-cycle delay and `MAX_TOKENS=3`. `LANES=8`, `BASE_DEPTH=2` gives lane 7 a delay of 9 and `in_flight` max 44.
